instr_encoder_queue: RTL
========================

Name: instr_encoder_queue

Overview:
Sequential instruction source that feeds the control decoder and datapath. It accepts field-level instruction requests (class, registers, funct, immediate) over a valid/ready handshake and encodes them into 32-bit RV32I words for R, I-ALU, LOAD, STORE and BEQ. Encoded words are buffered in a small FIFO and presented to the decode stage as instruction_code under a second valid/ready handshake. Used as the program-stream driver for control/datapath bring-up and for self-checking benches.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
PTR_W, $clog2(DEPTH), FIFO pointer width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  encoder can accept a request; equals !full
req_type  input  3  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BEQ, 5..7 illegal
req_rd  input  5  destination register
req_rs1  input  5  source register 1
req_rs2  input  5  source register 2
req_funct3  input  3  funct3 field
req_funct7  input  7  funct7 field (R only)
req_imm  input  13  immediate; [11:0] for I/LOAD/STORE; signed byte offset [12:0] for BEQ, bit0 ignored
instr_valid  output  1  instruction_code is valid; equals !empty
instr_ready  input  1  consumer accepts instruction_code
instruction_code  output  32  head-of-FIFO encoded instruction
err  output  1  one-cycle pulse when an illegal req_type is accepted
count  output  PTR_W+1  current FIFO occupancy

Behaviour:
- Reset is synchronous, active-high, one clk, and is the only reset. Reset values: pointers 0, count 0, instr_valid 0, req_ready 1, err 0, instruction_code 32'h0 (the head register is cleared).
- Reset asserted mid-stream discards all queued entries and ignores any handshake in the same cycle.
- Push when req_valid && req_ready. Pop when instr_valid && instr_ready.
- Latency: a request pushed into an empty FIFO appears on instruction_code with instr_valid=1 on the next cycle. There is no combinational bypass.
- Full (count==DEPTH): req_ready=0. A pop in that cycle frees a slot, and req_ready rises on the following cycle. There is no same-cycle push-on-pop when full.
- Simultaneous push and pop when 0<count<DEPTH: count is unchanged, and the new entry is written behind the head.
- Empty: instr_valid=0, and instruction_code holds the last popped value (0 after reset).
- Pointers wrap modulo DEPTH.
- While instr_valid=1 and instr_ready=0, instruction_code stays stable.
- Encoding, combinational on request fields and registered at push:
  - R: {funct7, rs2, rs1, funct3, rd, 7'b0110011}
  - I-ALU: {imm[11:0], rs1, funct3, rd, 7'b0010011}
  - LOAD: {imm[11:0], rs1, funct3, rd, 7'b0000011}
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}. req_funct3 is ignored for BEQ.
- Illegal req_type (5..7): the request is still handshaken (consumed) but not enqueued. err=1 for exactly the cycle after acceptance. count is unchanged.
- Back-to-back illegal requests produce consecutive err pulses.

Test Plan:
1. After reset, push ADDI (type 1, rd=1, rs1=0, f3=0, imm=5) with instr_ready=1. Required: instr_valid=1 one cycle later with instruction_code=32'h00500093, and the entry is popped on that cycle.
2. Hold instr_ready=0 and push LW (type 2, rd=2, rs1=1, f3=2, imm=8), SW (type 3, rs2=2, rs1=1, f3=2, imm=12), ADD (type 0, rd=3, rs1=1, rs2=2, f3=0, f7=0), then BEQ (type 4, rs1=1, rs2=2, imm=8). Required: count=4 and req_ready=0 after the 4th push, and a 5th request stalls. Then set instr_ready=1 and check the pops in order: 32'h0080A103, 32'h0020A623, 32'h002081B3, 32'h00208463. instr_valid must drop after the last pop.
3. Push BEQ with rs1=1, rs2=2, imm=13'h1FFC (offset -4). Required: instruction_code=32'hFE208EE3.
4. Push req_type=6 into an empty FIFO. Required: req_ready=1 in the accept cycle, err=1 for exactly one cycle after, and count stays 0 with instr_valid=0.
5. Hold count=2 and drive push+pop every cycle for 8 cycles. Required: count stays 2 and output order matches push order through pointer wrap.
6. With 3 entries queued, assert reset for 1 cycle while req_valid=1 and instr_ready=1. Required: next cycle count=0, instr_valid=0, instruction_code=0, err=0, and nothing is enqueued.

Source files
------------

// File: rtl/instr_encoder_queue.sv
`default_nettype none
// ============================================================================
// Module  : instr_encoder_queue
// Brief   : Encodes field-level RV32I requests and queues them for decode.
// Revision: 1.0
// ============================================================================
module instr_encoder_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_type,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [2:0]       req_funct3,
  input  logic [6:0]       req_funct7,
  input  logic [12:0]      req_imm,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instruction_code,
  output logic             err,
  output logic [PTR_W:0]   count
);

  localparam logic [2:0]     c_T_R     = 3'd0;
  localparam logic [2:0]     c_T_IALU  = 3'd1;
  localparam logic [2:0]     c_T_LOAD  = 3'd2;
  localparam logic [2:0]     c_T_STORE = 3'd3;
  localparam logic [2:0]     c_T_BEQ   = 3'd4;
  localparam logic [PTR_W:0] c_FULL    = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [31:0]      r_code;
  logic             r_err;

  logic             w_legal;
  logic             w_accept;
  logic             w_enq;
  logic             w_pop;
  logic [31:0]      w_enc;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [PTR_W:0]   w_count_nxt;
  logic [31:0]      w_code_nxt;

  assign req_ready        = (r_count != c_FULL);
  assign instr_valid      = (r_count != '0);
  assign instruction_code = r_code;
  assign err              = r_err;
  assign count            = r_count;

  assign w_legal  = (req_type <= c_T_BEQ);
  assign w_accept = req_valid && req_ready;
  assign w_enq    = w_accept && w_legal;
  assign w_pop    = instr_valid && instr_ready;
  assign w_rd_nxt = r_rd_ptr + PTR_W'(w_pop);

  always_comb begin
    w_enc = 32'h0;
    case (req_type)
      c_T_R:     w_enc = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, 7'b0110011};
      c_T_IALU:  w_enc = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0010011};
      c_T_LOAD:  w_enc = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0000011};
      c_T_STORE: w_enc = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], 7'b0100011};
      c_T_BEQ:   w_enc = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                          req_imm[4:1], req_imm[11], 7'b1100011};
      default:   w_enc = 32'h0;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_enq, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // The head register tracks the next entry; a slot written this cycle is not
  // yet in r_mem, so take it straight from the encoder. Empty holds last value.
  always_comb begin
    w_code_nxt = r_code;
    if (w_count_nxt != '0) begin
      if (w_enq && (r_wr_ptr == w_rd_nxt)) begin
        w_code_nxt = w_enc;
      end else begin
        w_code_nxt = r_mem[w_rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq && !reset) begin
      r_mem[r_wr_ptr] <= w_enc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_code   <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_code   <= w_code_nxt;
      r_err    <= w_accept && !w_legal;
    end
  end

endmodule
`default_nettype wire
